// File: rtl/fwl_pkg.sv
// Shared types and constants for the flow_water_lights input path.
// Debounce state encoding, default timing constants and freq codes.
package fwl_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } deb_state_e;

    localparam int unsigned DEB_CYCLES_DEF  = 1_000_000;
    localparam int unsigned LONG_CYCLES_DEF = 50_000_000;
    localparam int unsigned CNT_W_DEF       = 26;

    localparam logic [1:0] FREQ_SLOW = 2'b00;
    localparam logic [1:0] FREQ_MED  = 2'b01;
    localparam logic [1:0] FREQ_FAST = 2'b10;
    localparam logic [1:0] FREQ_MAX  = 2'b11;

endpackage

// File: rtl/fwl_debounce_ch.sv
// One debounced input bit: 2-flop synchroniser, 4-state FSM and
// saturating stability counter.
import fwl_pkg::*;

module fwl_debounce_ch #(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    deb_state_e       state;
    logic             s;

    assign s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            cnt   <= '0;
            state <= S_LOW;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            unique case (state)
                S_LOW: begin
                    if (s) begin
                        state <= S_RISE;
                        cnt   <= '0;
                    end
                end
                S_RISE: begin
                    if (!s) begin
                        state <= S_LOW;
                    end else if (cnt == LAST) begin
                        state <= S_HIGH;
                        level <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        state <= S_FALL;
                        cnt   <= '0;
                    end
                end
                S_FALL: begin
                    if (s) begin
                        state <= S_HIGH;
                    end else if (cnt == LAST) begin
                        state <= S_LOW;
                        level <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_LOW;
            endcase
        end
    end

endmodule

// File: rtl/fwl_input_conditioner.sv
// Input front end for flow_water_lights: debounced button and freq_set.
// Optional long-press detector enabled by FWL_LONG_PRESS_EN.
import fwl_pkg::*;

module fwl_input_conditioner #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_raw,
    input  logic [1:0] freq_raw,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [1:0] freq_set,
    output logic       freq_chg,
    output logic       long_press
);

    logic       btn_q;
    logic [1:0] freq_q;

    fwl_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (button_raw),
        .level (btn_level)
    );

    fwl_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_freq0 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (freq_raw[0]),
        .level (freq_set[0])
    );

    fwl_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_freq1 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (freq_raw[1]),
        .level (freq_set[1])
    );

    // Delayed copies reset to the reset-state levels, so no pulse on reset exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= 1'b0;
            freq_q      <= 2'b00;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            freq_chg    <= 1'b0;
        end else begin
            btn_q       <= btn_level;
            freq_q      <= freq_set;
            btn_press   <= btn_level & ~btn_q;
            btn_release <= ~btn_level & btn_q;
            freq_chg    <= |(freq_set ^ freq_q);
        end
    end

`ifdef FWL_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             fired;

    // fired blocks repeats until the debounced level drops again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            fired      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (!btn_level) begin
                hold_cnt <= '0;
                fired    <= 1'b0;
            end else if (hold_cnt == LONG_LAST && !fired) begin
                long_press <= 1'b1;
                fired      <= 1'b1;
            end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule
